icache_ctrl: RTL

ICACHE_CTRL -- requirements
Module: icache_ctrl

---
 rtl/icache_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/icache_ctrl.sv
// icache_ctrl: instruction-cache miss controller; hits pass through combinationally, one outstanding load, rejected loads retried each cycle.
// Fill is written the cycle the matching memory tag returns; ICACHE_FILL_BYPASS_EN also forwards that data to matching ports.
module icache_ctrl (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0][31:0] proc2Icache_addr,
  output logic [2:0][63:0] Icache2proc_data,
  output logic [2:0]       Icache2proc_valid,
  output logic [2:0][4:0]  current_index,
  output logic [2:0][7:0]  current_tag,
  input  logic [2:0][63:0] cachemem_data,
  input  logic [2:0]       cachemem_valid,
  output logic             data_write_enable,
  output logic [4:0]       wr_index,
  output logic [7:0]       wr_tag,
  output logic [1:0]       proc2Imem_command,
  output logic [31:0]      proc2Imem_addr,
  input  logic [3:0]       Imem2proc_response,
  input  logic [63:0]      Imem2proc_data,
  input  logic [3:0]       Imem2proc_tag
);

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_LOAD = 2'd1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t      state, state_nxt;
  logic [28:0] blk_addr, blk_addr_nxt;
  logic [3:0]  mem_tag, mem_tag_nxt;
  logic        miss_vld;
  logic [28:0] miss_blk;
  logic        unused_bits;

  assign unused_bits = ^{proc2Icache_addr[0][2:0], proc2Icache_addr[1][2:0],
                         proc2Icache_addr[2][2:0], Imem2proc_data};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      current_index[i] = proc2Icache_addr[i][7:3];
      current_tag[i]   = proc2Icache_addr[i][15:8];
    end
  end

  // Scan downwards so the oldest (lowest-numbered) missing port wins.
  always_comb begin
    miss_vld = 1'b0;
    miss_blk = '0;
    for (int i = 2; i >= 0; i--) begin
      if (!cachemem_valid[i]) begin
        miss_vld = 1'b1;
        miss_blk = proc2Icache_addr[i][31:3];
      end
    end
  end

  assign proc2Imem_addr = {blk_addr, 3'b000};
  assign wr_index       = blk_addr[4:0];
  assign wr_tag         = blk_addr[12:5];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      blk_addr <= '0;
      mem_tag  <= '0;
    end else begin
      state    <= state_nxt;
      blk_addr <= blk_addr_nxt;
      mem_tag  <= mem_tag_nxt;
    end
  end

  always_comb begin
    state_nxt         = state;
    blk_addr_nxt      = blk_addr;
    mem_tag_nxt       = mem_tag;
    proc2Imem_command = CMD_NONE;
    data_write_enable = 1'b0;
    case (state)
      // Fills only complete in WAIT, so an IDLE miss never aliases a block being written.
      IDLE: begin
        if (miss_vld) begin
          blk_addr_nxt = miss_blk;
          state_nxt    = REQ;
        end
      end
      REQ: begin
        if (!miss_vld || (miss_blk != blk_addr)) begin
          state_nxt = IDLE;
        end else begin
          proc2Imem_command = CMD_LOAD;
          if (Imem2proc_response != 4'd0) begin
            mem_tag_nxt = Imem2proc_response;
            state_nxt   = WAIT;
          end
        end
      end
      WAIT: begin
        if ((mem_tag != 4'd0) && (Imem2proc_tag == mem_tag)) begin
          data_write_enable = 1'b1;
          state_nxt         = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Icache2proc_data  = cachemem_data;
    Icache2proc_valid = cachemem_valid;
`ifdef ICACHE_FILL_BYPASS_EN
    for (int i = 0; i < 3; i++) begin
      if (data_write_enable && (current_index[i] == wr_index) && (current_tag[i] == wr_tag)) begin
        Icache2proc_data[i]  = Imem2proc_data;
        Icache2proc_valid[i] = 1'b1;
      end
    end
`endif
  end

endmodule
